flit_in_fifo: RTL and testbench
===============================

Name: flit_in_fifo

Overview:
Parametrised input-port flit buffer for the NoC router; the successor to the fixed 40x20 write-only input buffer.
- Stores incoming flits in a circular FIFO with valid/ready handshakes on both sides.
- Presents the head flit split into payload and tag fields to the downstream route/arbiter logic.
- Drives full, almost-full and occupancy status for upstream backpressure, plus a sticky overflow flag for dropped flits.

Parameters:
FLIT_W, 20, flit width in bits
TAG_W, 4, low-order tag/control bits; payload = flit[FLIT_W-1:TAG_W]
DEPTH, 40, number of flit entries; need not be a power of two
ADDR_W, 6, pointer width; must satisfy 2^ADDR_W >= DEPTH
CNT_W, 7, occupancy width; must satisfy 2^CNT_W > DEPTH
AF_LEVEL, 36, almost_full asserts when count >= AF_LEVEL; must satisfy 1 <= AF_LEVEL <= DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream flit valid
in_ready  out  1  FIFO can accept a flit; equals !full
datain  in  FLIT_W  incoming flit
out_valid  out  1  head flit available; equals !empty
out_ready  in  1  downstream consumes head flit
out_payload  out  FLIT_W-TAG_W  head flit [FLIT_W-1:TAG_W]; 0 when empty
out_tag  out  TAG_W  head flit [TAG_W-1:0]; 0 when empty
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  sticky: a flit was presented while full
clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst low, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: empty=1, full=0, almost_full=0, in_ready=1, out_valid=0, out_payload=0, out_tag=0. Memory is not reset; no output may ever expose unwritten memory.
- Push: in_valid && in_ready at a rising edge writes datain to mem[wr_ptr] and advances wr_ptr.
- Pop: out_valid && out_ready at a rising edge advances rd_ptr.
- Wrap: pointers go from DEPTH-1 to 0 by explicit compare, not binary rollover (DEPTH=40 needs this).
- Count: count +1 on push only, -1 on pop only, unchanged on push and pop together.
- full, empty, almost_full, in_ready and out_valid are decoded from registered count.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.
- Head output is first-word fall-through: out_payload and out_tag are a combinational read of mem[rd_ptr], gated to 0 when empty.
- Latency: a flit pushed at edge N appears on the outputs after edge N; there is no same-cycle bypass.
- Full: in_ready=0 even if out_ready=1 in that cycle, so no push occurs.
  - in_valid=1 while full drops the flit and sets overflow at that edge.
  - Memory and pointers are unchanged by a dropped flit.
- Empty: out_ready is ignored; rd_ptr and count are unchanged.
- Simultaneous push+pop with 0<count<DEPTH: both pointers advance and count holds, including when either pointer wraps in the same cycle.
- overflow clears on clr_ovf=1. A new drop in the same cycle wins (overflow=1).
- Reset mid-operation: all pointers, count and flags return to reset values immediately. Contents are discarded and are never presented afterwards.
- in_valid=0: datain is ignored; X on datain must not propagate.

Test Plan:
1. Reset then idle -> empty=1, in_ready=1, out_valid=0, count=0, out_payload=0, out_tag=0, overflow=0.
2. Push single flit 20'hABCD5, out_ready=0 -> next cycle out_valid=1, out_payload=16'hABCD, out_tag=4'h5, count=1. Pop -> empty=1.
3. Push 40 flits 20'h00010..20'h00280 (i<<4) with out_ready=0:
   - almost_full rises when count reaches 36; full=1 and in_ready=0 at count=40.
   - 41st flit 20'hFFFFF with in_valid=1 -> dropped, overflow=1, count stays 40.
   - Drain all 40 -> payloads 16'h0001..16'h0028 in order; 20'hFFFFF is never seen.
4. Continuous push+pop at count=5 for 100 cycles (pointers wrap twice) -> count stays 5; output sequence equals input sequence delayed by 5 flits.
5. At count=40, assert in_valid=1 and out_ready=1 together -> pop occurs, push is refused (in_ready=0), overflow=1, count=39.
   - Then clr_ovf=1 in the same cycle as another drop -> overflow stays 1.
   - clr_ovf=1 alone -> overflow=0.
6. Assert rst low mid-stream at count=17 -> outputs take reset values asynchronously.
   - After release, push 20'h12340 -> out_payload=16'h1234, count=1; no stale flits appear.

Source files
------------

// File: rtl/flit_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : flit_in_fifo
// Brief    : Parametrised first-word-fall-through input flit buffer for the
//            NoC router, with occupancy status and a sticky overflow flag.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module flit_in_fifo #(
    parameter int FLIT_W   = 20,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 40,
    parameter int ADDR_W   = 6,
    parameter int CNT_W    = 7,
    parameter int AF_LEVEL = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLIT_W-1:0]       datain,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FLIT_W-TAG_W-1:0] out_payload,
    output logic [TAG_W-1:0]        out_tag,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    overflow,
    input  logic                    clr_ovf
);

    localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_AF_LEVEL = CNT_W'(AF_LEVEL);
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [FLIT_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              overflow_q, overflow_d;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [FLIT_W-1:0] w_head;

    // All status is decoded from the registered count only, so neither
    // handshake side has a combinational path into the other.
    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;
    assign w_drop  = in_valid && w_full;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // DEPTH need not be a power of two, so wrap by explicit compare.
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + ADDR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; datain is only sampled on a push.
    always_ff @(posedge clk) begin
        if (w_push && rst) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    assign w_head = w_empty ? '0 : mem[rd_ptr_q];

    assign out_payload = w_head[FLIT_W-1:TAG_W];
    assign out_tag     = w_head[TAG_W-1:0];
    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (count_q >= C_AF_LEVEL);
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_flit_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_in_fifo
// Brief    : Self-checking bench for flit_in_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_in_fifo;

    localparam int DEPTH = 40;
    localparam int AF    = 36;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] datain = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_payload;
    logic [3:0]  out_tag;
    logic [6:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    logic [19:0] q[$];
    bit          ovf = 1'b0;

    flit_in_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .datain      (datain),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_tag     (out_tag),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    // {count, full, empty, almost_full, in_ready, out_valid, overflow, payload, tag}
    function automatic logic [32:0] dut_status();
        return {count, full, empty, almost_full, in_ready, out_valid, overflow,
                out_payload, out_tag};
    endfunction

    function automatic logic [32:0] exp_status();
        int          n;
        logic [19:0] h;
        n = q.size();
        h = (n != 0) ? q[0] : 20'h0;
        return {7'(n), n == DEPTH, n == 0, n >= AF, n != DEPTH, n != 0, ovf, h};
    endfunction

    // One clock of stimulus; the model applies the FIFO rules to the queue.
    task automatic cycle(input logic iv, input logic [19:0] d, input logic ordy,
                         input logic clr);
        bit was_full;
        bit was_empty;
        in_valid  = iv;
        datain    = iv ? d : 20'bx;
        out_ready = ordy;
        clr_ovf   = clr;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        if (ordy && !was_empty) void'(q.pop_front());
        if (iv && !was_full) q.push_back(d);
        if (iv && was_full) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] got;
        #1;
        got = dut_status();
        vectors++;
        if (got !== {7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0}) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", got,
                     {7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b0, 20'h0, 1'b1, 1'b0);
        got = dut_status();
        vectors++;
        if (got !== exp_status()) begin
            miscompares++;
            $display("FAIL reset_idle got=%h exp=%h", got, exp_status());
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        datain   = 20'hABCD5;
        out_ready = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_bypass got=%b exp=0", out_valid);
        end
        cycle(1'b1, 20'hABCD5, 1'b0, 1'b0);
        vectors++;
        if ({out_valid, out_payload, out_tag, count} !== {1'b1, 16'hABCD, 4'h5, 7'd1}) begin
            miscompares++;
            $display("FAIL single_head got=%b/%h/%h/%0d exp=1/abcd/5/1",
                     out_valid, out_payload, out_tag, count);
        end
        cycle(1'b0, 20'h0, 1'b1, 1'b0);
        vectors++;
        if (dut_status() !== exp_status() || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pop got=%h exp=%h", dut_status(), exp_status());
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 20'(i << 4), 1'b0, 1'b0);
            vectors++;
            if (dut_status() !== exp_status() || almost_full !== (i >= AF)
                || full !== (i == DEPTH)) begin
                miscompares++;
                $display("FAIL fill_%0d got=%h exp=%h", i, dut_status(), exp_status());
            end
        end
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b0);
        vectors++;
        if ({overflow, count, in_ready} !== {1'b1, 7'd40, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_drop got=ovf%b cnt%0d rdy%b exp=ovf1 cnt40 rdy0",
                     overflow, count, in_ready);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            vectors++;
            if (out_payload !== 16'(i) || dut_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL drain_%0d got=%h exp=%h", i, out_payload, 16'(i));
            end
            cycle(1'b0, 20'h0, 1'b1, 1'b1);
        end
        vectors++;
        if (dut_status() !== exp_status() || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end got=%h exp=%h", dut_status(), exp_status());
        end
    endtask

    task automatic test_stream();
        logic [19:0] sent[$];
        int          nrecv;
        nrecv = 0;
        for (int i = 0; i < 5; i++) begin
            sent.push_back(20'($urandom));
            cycle(1'b1, sent[$], 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if ({out_payload, out_tag} !== sent[nrecv] || count !== 7'd5
                || dut_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL stream_%0d got=%h cnt%0d exp=%h cnt5",
                         i, {out_payload, out_tag}, count, sent[nrecv]);
            end
            nrecv++;
            sent.push_back(20'($urandom));
            cycle(1'b1, sent[$], 1'b1, 1'b0);
        end
    endtask

    task automatic test_full_simul();
        while (q.size() < DEPTH) cycle(1'b1, 20'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 20'hFFFFF, 1'b1, 1'b0);
        vectors++;
        if ({overflow, count} !== {1'b1, 7'd39} || dut_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL full_simul got=ovf%b cnt%0d exp=ovf1 cnt39", overflow, count);
        end
        cycle(1'b1, 20'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b1 || dut_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL clr_vs_drop got=%b exp=1", overflow);
        end
        cycle(1'b0, 20'h0, 1'b0, 1'b1);
        vectors++;
        if (overflow !== 1'b0 || dut_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL clr_alone got=%b exp=0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() > 17) cycle(1'b0, 20'h0, 1'b1, 1'b0);
        vectors++;
        if (count !== 7'd17) begin
            miscompares++;
            $display("FAIL pre_reset_count got=%0d exp=17", count);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (dut_status() !== {7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0}) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", dut_status(),
                     {7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0});
        end
        q.delete();
        ovf = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 20'h12340, 1'b0, 1'b0);
        vectors++;
        if ({out_payload, count} !== {16'h1234, 7'd1} || dut_status() !== exp_status()) begin
            miscompares++;
            $display("FAIL post_reset got=%h cnt%0d exp=1234 cnt1", out_payload, count);
        end
        cycle(1'b0, 20'h0, 1'b1, 1'b0);
        cycle(1'b0, 20'h0, 1'b1, 1'b0);
        vectors++;
        if (dut_status() !== exp_status() || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_stale got=%h exp=%h", dut_status(), exp_status());
        end
    endtask

    task automatic test_random();
        int p_in;
        int p_out;
        for (int i = 0; i < 400; i++) begin
            p_in  = (i < 200) ? 70 : 30;
            p_out = (i < 200) ? 40 : 70;
            cycle($urandom_range(0, 99) < p_in, 20'($urandom),
                  $urandom_range(0, 99) < p_out, $urandom_range(0, 99) < 5);
            vectors++;
            if (dut_status() !== exp_status()) begin
                miscompares++;
                $display("FAIL random_%0d got=%h exp=%h", i, dut_status(), exp_status());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_stream();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
